// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operand request with valid/ready,
// registered result with valid/ready.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero_flag;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, a, b, control, out_ready,
    input  in_ready, out_valid, result, result_hi, zero_flag, overflow, illegal
  );

  modport slave (
    input  in_valid, a, b, control, out_ready,
    output in_ready, out_valid, result, result_hi, zero_flag, overflow, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: one-cycle legacy ops plus iterative unsigned MULU/DIVU,
// all results registered and presented through a valid/ready handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset_n,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;
  logic             overflow_reg;
  logic             illegal_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             is_mul;
  logic             is_div;

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    shamt   = bus.a[SHW-1:0];
    is_mul  = (bus.control == 5'b10000);
    is_div  = (bus.control == 5'b10010);
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    if (bus.control[4]) begin
      alu_ill = !(is_mul || is_div);
    end else begin
      case (bus.control[2:0])
        3'b000: begin
          alu_res = sum;
          alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
        3'b100: begin
          alu_res = diff;
          alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        end
        3'b001: alu_res = bus.a & bus.b;
        3'b101: alu_res = bus.a | bus.b;
        3'b010: alu_res = bus.a ^ bus.b;
        3'b110: alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        3'b011: begin
          if (bus.control[3]) alu_ill = 1'b1;
          else                alu_res = bus.b << shamt;
        end
        default: begin
          if (bus.control[3]) alu_res = $signed(bus.b) >>> shamt;
          else                alu_res = bus.b >> shamt;
        end
      endcase
    end
  end

  // Shift-add step: acc:lo holds partial product with the multiplier draining out of lo.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] mul_lo_next;

  always_comb begin
    mul_sum = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    {mul_acc_next, mul_lo_next} = {mul_sum, lo_reg[WIDTH-1:1]};
  end

  // Restoring step: acc is the partial remainder, lo shifts dividend out and quotient in.
  // A zero divisor always passes the trial, giving all-ones quotient and remainder = a.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_trial;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  always_comb begin
    div_shift    = {acc_reg, lo_reg[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, opnd_reg});
    div_trial    = div_shift[WIDTH-1:0] - opnd_reg;
    div_rem_next = div_ge ? div_trial : div_shift[WIDTH-1:0];
    div_quo_next = {lo_reg[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      acc_reg       <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b1;
      overflow_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            acc_reg <= '0;
            if (is_mul) begin
              lo_reg    <= bus.b;
              opnd_reg  <= bus.a;
              count_reg <= CW'(WIDTH);
              state_reg <= MUL;
            end else if (is_div) begin
              lo_reg    <= bus.a;
              opnd_reg  <= bus.b;
              count_reg <= CW'(WIDTH);
              state_reg <= DIV;
            end else begin
              result_reg    <= alu_res;
              result_hi_reg <= '0;
              zero_reg      <= (alu_res == '0);
              overflow_reg  <= alu_ovf;
              illegal_reg   <= alu_ill;
              state_reg     <= DONE;
            end
          end
        end
        MUL: begin
          acc_reg   <= mul_acc_next;
          lo_reg    <= mul_lo_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            result_reg    <= mul_lo_next;
            result_hi_reg <= mul_acc_next;
            zero_reg      <= (mul_lo_next == '0);
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DIV: begin
          acc_reg   <= div_rem_next;
          lo_reg    <= div_quo_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            result_reg    <= div_quo_next;
            result_hi_reg <= div_rem_next;
            zero_reg      <= (div_quo_next == '0);
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.zero_flag = zero_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) m32 ();
  alu_multicycle_if #(.WIDTH(16)) m16 ();

  alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(m32));
  alu_multicycle #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(m16));

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b01111;
  localparam logic [4:0] OP_MULU = 5'b10000;
  localparam logic [4:0] OP_DIVU = 5'b10010;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zf;
    logic        ov;
    logic        ill;
  } exp_t;

  logic [4:0] single_ops [15] = '{5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00001,
                                  5'b01001, 5'b00101, 5'b01101, 5'b00010, 5'b01010,
                                  5'b00110, 5'b01110, 5'b00011, 5'b00111, 5'b01111};

  function automatic exp_t model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint s;
    logic [63:0] p;
    int sh;
    e  = '0;
    sh = int'(x[4:0]);
    casez (c)
      5'b0?000: begin
        s = longint'($signed(x)) + longint'($signed(y));
        e.res = s[31:0];
        e.ov  = (s > SMAX) || (s < SMIN);
      end
      5'b0?100: begin
        s = longint'($signed(x)) - longint'($signed(y));
        e.res = s[31:0];
        e.ov  = (s > SMAX) || (s < SMIN);
      end
      5'b0?001: e.res = x & y;
      5'b0?101: e.res = x | y;
      5'b0?010: e.res = x ^ y;
      5'b0?110: e.res = {y[15:0], 16'h0000};
      5'b00011: e.res = y << sh;
      5'b00111: e.res = y >> sh;
      5'b01111: e.res = $signed(y) >>> sh;
      5'b10000: begin
        p = {32'h0, x} * {32'h0, y};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      5'b10010: begin
        if (y == 0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = x;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zf = (e.res == 0);
    return e;
  endfunction

  function automatic int lat_of(input logic [4:0] c);
    return (c == OP_MULU || c == OP_DIVU) ? 33 : 1;
  endfunction

  function automatic exp_t sample32();
    return {m32.result, m32.result_hi, m32.zero_flag, m32.overflow, m32.illegal};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request on the 32-bit DUT (called #1 after a rising edge, DUT idle)
  // and wait for out_valid; lat counts edges from the accept edge.
  task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    m32.control  = c;
    m32.a        = x;
    m32.b        = y;
    m32.in_valid = 1'b1;
    @(posedge clk); #1;
    m32.in_valid = 1'b0;
    lat = 1;
    while (m32.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    m32.out_ready = 1'b1;
    @(posedge clk); #1;
    m32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m32.out_valid, m32.in_ready, sample32()} !== {1'b0, 1'b1, 64'h0, 3'b100}) begin
      errors++;
      $display("FAIL reset32 got valid=%b ready=%b out=%h required valid=0 ready=1 out=%h",
               m32.out_valid, m32.in_ready, sample32(), {64'h0, 3'b100});
    end
    checks++;
    if ({m16.out_valid, m16.in_ready, m16.result, m16.result_hi, m16.zero_flag, m16.overflow, m16.illegal}
        !== {1'b0, 1'b1, 32'h0, 3'b100}) begin
      errors++;
      $display("FAIL reset16 got valid=%b ready=%b res=%h hi=%h zf=%b required 0 1 0 0 1",
               m16.out_valid, m16.in_ready, m16.result, m16.result_hi, m16.zero_flag);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    int lat;
    exp_t got;
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({32'h8000_0000, 32'h0, 3'b010}) || lat != 1) begin
      errors++;
      $display("FAIL add_ovf got %h lat %0d required %h lat 1", got, lat, {32'h8000_0000, 32'h0, 3'b010});
    end
    consume();
  endtask

  task automatic test_sub_sra();
    int lat;
    exp_t got;
    run_op(OP_SUB, 32'd5, 32'd5, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({64'h0, 3'b100}) || lat != 1) begin
      errors++;
      $display("FAIL sub_zero got %h lat %0d required %h lat 1", got, lat, {64'h0, 3'b100});
    end
    consume();
    run_op(OP_SRA, 32'd4, 32'h8000_0000, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({32'hF800_0000, 32'h0, 3'b000}) || lat != 1) begin
      errors++;
      $display("FAIL sra got %h lat %0d required %h lat 1", got, lat, {32'hF800_0000, 32'h0, 3'b000});
    end
    consume();
  endtask

  task automatic test_mulu();
    int lat;
    exp_t got;
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({32'h0000_0001, 32'hFFFF_FFFE, 3'b000}) || lat != 33) begin
      errors++;
      $display("FAIL mulu_max got %h lat %0d required %h lat 33", got, lat,
               {32'h0000_0001, 32'hFFFF_FFFE, 3'b000});
    end
    consume();
  endtask

  task automatic test_divu();
    int lat;
    exp_t got;
    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({32'd14, 32'd2, 3'b000}) || lat != 33) begin
      errors++;
      $display("FAIL divu_100_7 got %h lat %0d required %h lat 33", got, lat, {32'd14, 32'd2, 3'b000});
    end
    consume();
    run_op(OP_DIVU, 32'h1234, 32'h0, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({32'hFFFF_FFFF, 32'h1234, 3'b000}) || lat != 33) begin
      errors++;
      $display("FAIL divu_by0 got %h lat %0d required %h lat 33", got, lat,
               {32'hFFFF_FFFF, 32'h1234, 3'b000});
    end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    exp_t snap, got, want;
    logic [31:0] x, y;
    run_op(OP_ADD, 32'h0000_1000, 32'h0000_0234, lat);
    snap = model(OP_ADD, 32'h0000_1000, 32'h0000_0234);
    x = $urandom;
    y = $urandom;
    m32.control  = OP_SUB;
    m32.a        = x;
    m32.b        = y;
    m32.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      got = sample32();
      checks++;
      if (got !== snap || m32.out_valid !== 1'b1 || m32.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got %h valid=%b ready=%b required %h valid=1 ready=0",
                 i, got, m32.out_valid, m32.in_ready, snap);
      end
    end
    m32.out_ready = 1'b1;
    @(posedge clk); #1;
    m32.out_ready = 1'b0;
    checks++;
    if (m32.in_ready !== 1'b1 || m32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got ready=%b valid=%b required ready=1 valid=0",
               m32.in_ready, m32.out_valid);
    end
    @(posedge clk); #1;
    m32.in_valid = 1'b0;
    got  = sample32();
    want = model(OP_SUB, x, y);
    checks++;
    if (got !== want || m32.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_next got %h valid=%b required %h valid=1", got, m32.out_valid, want);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [4:0] c;
    logic [31:0] x, y;
    exp_t got, want;
    m32.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c = single_ops[$urandom_range(0, 14)];
      x = rand_operand();
      y = rand_operand();
      m32.control  = c;
      m32.a        = x;
      m32.b        = y;
      m32.in_valid = 1'b1;
      @(posedge clk); #1;
      got  = sample32();
      want = model(c, x, y);
      checks++;
      if (got !== want || m32.out_valid !== 1'b1 || m32.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result_%0d op %b got %h valid=%b ready=%b required %h valid=1 ready=0",
                 k, c, got, m32.out_valid, m32.in_ready, want);
      end
      @(posedge clk); #1;
      checks++;
      if (m32.out_valid !== 1'b0 || m32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle_%0d got valid=%b ready=%b required valid=0 ready=1",
                 k, m32.out_valid, m32.in_ready);
      end
    end
    m32.in_valid  = 1'b0;
    m32.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [4:0] c;
    logic [31:0] x, y;
    exp_t got, want;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0, 1: c = single_ops[$urandom_range(0, 14)];
        2:    c = OP_MULU;
        3:    c = OP_DIVU;
        default: begin
          c = 5'($urandom_range(16, 31));
          if (c == OP_MULU || c == OP_DIVU) c = 5'b01011;
        end
      endcase
      x = rand_operand();
      y = rand_operand();
      run_op(c, x, y, lat);
      got  = sample32();
      want = model(c, x, y);
      checks++;
      if (got !== want || lat != lat_of(c)) begin
        errors++;
        $display("FAIL random_%0d op %b a %h b %h got %h lat %0d required %h lat %0d",
                 k, c, x, y, got, lat, want, lat_of(c));
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    exp_t got;
    m32.control  = OP_DIVU;
    m32.a        = 32'hDEAD_BEEF;
    m32.b        = 32'd3;
    m32.in_valid = 1'b1;
    @(posedge clk); #1;
    m32.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m32.out_valid, m32.in_ready, sample32()} !== {1'b0, 1'b1, 64'h0, 3'b100}) begin
      errors++;
      $display("FAIL reset_mid_div got valid=%b ready=%b out=%h required valid=0 ready=1 out=%h",
               m32.out_valid, m32.in_ready, sample32(), {64'h0, 3'b100});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40 && m32.out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (m32.out_valid !== 1'b0 || m32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_aborted got valid=%b ready=%b required valid=0 ready=1",
               m32.out_valid, m32.in_ready);
    end
    run_op(5'b10101, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    got = sample32();
    checks++;
    if (got !== exp_t'({64'h0, 3'b101}) || lat != 1) begin
      errors++;
      $display("FAIL illegal_10101 got %h lat %0d required %h lat 1", got, lat, {64'h0, 3'b101});
    end
    consume();
  endtask

  task automatic test_width16();
    logic [15:0] x, y, want_res;
    logic        want_ov;
    logic        sub;
    int          s;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        x = 16'h7FFF;
        y = 16'h0001;
        sub = 1'b0;
      end else begin
        x = 16'($urandom);
        y = 16'($urandom);
        sub = 1'($urandom_range(0, 1));
      end
      s = sub ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
      want_res = s[15:0];
      want_ov  = (s > 32767) || (s < -32768);
      m16.control  = sub ? OP_SUB : OP_ADD;
      m16.a        = x;
      m16.b        = y;
      m16.in_valid = 1'b1;
      @(posedge clk); #1;
      m16.in_valid = 1'b0;
      checks++;
      if ({m16.out_valid, m16.result, m16.result_hi, m16.zero_flag, m16.overflow, m16.illegal}
          !== {1'b1, want_res, 16'h0, (want_res == 16'h0), want_ov, 1'b0}) begin
        errors++;
        $display("FAIL w16_%0d a %h b %h sub %b got valid=%b res=%h hi=%h zf=%b ov=%b ill=%b required valid=1 res=%h ov=%b",
                 k, x, y, sub, m16.out_valid, m16.result, m16.result_hi, m16.zero_flag,
                 m16.overflow, m16.illegal, want_res, want_ov);
      end
      m16.out_ready = 1'b1;
      @(posedge clk); #1;
      m16.out_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m32.in_valid = 1'b0; m32.out_ready = 1'b0; m32.a = '0; m32.b = '0; m32.control = '0;
    m16.in_valid = 1'b0; m16.out_ready = 1'b0; m16.a = '0; m16.b = '0; m16.control = '0;
    test_reset();
    test_add_overflow();
    test_sub_sra();
    test_mulu();
    test_divu();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the single-cycle CPU ALU. It adds an iterative unsigned multiplier and divider beside the legacy one-cycle operations, all behind a valid/ready handshake. All results are registered. It sits in the execute stage of the multi-cycle/pipelined CPU, which stalls on `in_ready`/`out_valid`.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. Must be even and ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request present.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `a`, `b`  in  WIDTH  operands, sampled on accept.
- `control`  in  5  operation code, sampled on accept.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  primary result.
- `result_hi`  out  WIDTH  MULU high word / DIVU remainder; 0 for other ops.
- `zero_flag`  out  1  `result == 0`.
- `overflow`  out  1  signed overflow of ADD/SUB; 0 for other ops.
- `illegal`  out  1  undefined `control` code.

## Operation
Opcodes with `control[4]=0` keep the legacy encoding (x = don't care):
- x000: ADD.
- x100: SUB.
- x001: AND.
- x101: OR.
- x010: XOR.
- x110: LUI, `{b[WIDTH/2-1:0], WIDTH/2 zeros}`.
- 0011: SLL `b` by `a[SHW-1:0]`.
- 0111: SRL `b` by `a[SHW-1:0]`.
- 1111: SRA `b` by `a[SHW-1:0]`.
- 1011: illegal.

Opcodes with `control[4]=1`:
- 10000: MULU. Full 2·WIDTH-bit unsigned product; `result` = low word, `result_hi` = high word.
- 10010: DIVU. Restoring unsigned divide; `result` = quotient, `result_hi` = remainder.
- All other 1xxxx codes: illegal.

Result rules:
- Divide by zero: quotient all-ones, remainder = `a`; `illegal` = 0.
- Illegal op: `result` = 0, `result_hi` = 0, `zero_flag` = 1, `illegal` = 1, `overflow` = 0. Completes with single-cycle latency.
- `overflow` on ADD: operand signs equal and result sign differs. On SUB: operand signs differ and result sign differs from `a`.

State machine (IDLE, MUL, DIV, DONE):
- IDLE: `in_ready` = 1. On `in_valid`, latch the operands and `control`.
  - Single-cycle or illegal op: compute, load the output registers, go to DONE.
  - MULU: go to MUL with counter = WIDTH.
  - DIVU: go to DIV with counter = WIDTH.
- MUL: one shift-add step per cycle, counter decrements. At counter = 1, load the outputs and go to DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Same exit rule as MUL.
- DONE: `out_valid` = 1 and outputs stay stable. On `out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. `in_valid` in IDLE is never dropped.

## Timing
- Reset (asynchronous, while `reset_n`=0): state = IDLE, counter = 0.
  - `out_valid`, `result`, `result_hi`, `overflow`, `illegal` = 0.
  - `zero_flag` = 1.
  - `in_ready` = 1, since it is decoded from state.
  - Reset mid-MUL/DIV aborts the operation with no output.
- Single-cycle and illegal ops: accepted at edge N, `out_valid` high after edge N+1's predecessor, i.e. latency 1.
- MULU/DIVU: latency WIDTH+1 cycles from accept to `out_valid`.
- Throughput:
  - With `out_ready` held high, a single-cycle op occupies 2 cycles: DONE→IDLE costs one cycle.
  - `out_ready` low in DONE holds all outputs unchanged indefinitely.
- `in_ready` is never combinationally dependent on `out_ready`. No back-to-back accept is allowed while in DONE.
- Outputs change only on the edge that enters DONE, or on reset.

## Test plan
- Reset, then ADD `a`=7FFFFFFF, `b`=1 (WIDTH=32) → after 1 cycle `result`=80000000, `overflow`=1, `zero_flag`=0, `out_valid`=1.
- SUB 5−5, then SRA `b`=80000000 by `a`=4 → `result`=0 with `zero_flag`=1; then `result`=F8000000.
- MULU FFFFFFFF×FFFFFFFF → `out_valid` exactly 33 cycles after accept; `result`=00000001, `result_hi`=FFFFFFFE.
- DIVU 100/7 → `result`=14, `result_hi`=2. DIVU by 0 with `a`=1234 → `result`=FFFFFFFF, `result_hi`=1234.
- Hold `out_ready`=0 for 10 cycles in DONE while driving new `in_valid` → outputs stable, `in_ready`=0, new op accepted only after the handshake.
- Assert `reset_n`=0 mid-DIV (cycle 10), plus `control`=10101 → immediate IDLE/zeroed outputs; the later illegal op gives `illegal`=1, `result`=0. Repeat the ADD case at WIDTH=16.
